fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Read-side adapter for the team's synchronous FIFO.
- Drives the FIFO's rd_en, accepts its registered rd_data one cycle later, and re-presents the words as a valid/ready stream.
- A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so throughput is one word per cycle with no data loss under backpressure.
- Sits between any fifo_sync instance and a downstream stream consumer.

Parameters:
- DATA_WIDTH, 8, width of each data word; must match the attached FIFO.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_rd_en  output  1  combinational read strobe to the FIFO.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid in the cycle after an accepted read.
- m_valid  output  1  stream output holds a word.
- m_ready  input  1  consumer accepts the word this cycle.
- m_data  output  DATA_WIDTH  stream word (head of buffer).
- idle  output  1  nothing buffered, nothing in flight, FIFO empty.

Behaviour:
- Interface fixed: one clock clk; rst synchronous and active-high.
- Reset: occ=0, inflight=0, buffer entries=0, m_valid=0, m_data=0, idle=1 (fifo_empty is 1 after FIFO reset). fifo_rd_en is forced 0 while rst=1.
- Buffer state machine on occ:
  - EMPTY: 0 words.
  - ONE: head valid.
  - TWO: head and tail valid.
- Transition inputs:
  - fire = m_valid && m_ready.
  - arrive = inflight.
  - Capture on arrive: write the tail if occ=2-after-pop case applies, otherwise write the head.
  - Simultaneous fire+arrive in ONE: head <= fifo_rd_data; occ stays 1.
  - In TWO: fire moves tail into head.
- Read issue:
  - fifo_rd_en = !rst && !fifo_empty && (occ + inflight - fire) < 2.
  - inflight <= fifo_rd_en (registered).
- Overflow prohibition: occ never exceeds 2. A word arriving while occ=2 and !fire is a design error; assert in simulation.
- Output signals:
  - m_valid = (occ != 0).
  - m_data = head.
  - m_data stays stable while m_valid && !m_ready (AXI-style hold).
- Latency: a word in a non-empty FIFO with the buffer empty appears on m_valid 2 cycles after fifo_rd_en asserts.
  - Cycle N: rd_en.
  - Cycle N+1: fifo_rd_data valid, inflight=1.
  - Cycle N+2: m_valid.
- Throughput: with m_ready=1 and the FIFO non-empty, one word per cycle is sustained (occ=1, inflight=1 steady state).
- Ordering: strict FIFO order; no duplication or drop.
- Backpressure: m_ready=0 stops reads once occ+inflight=2.
- FIFO goes empty mid-stream: reads stop; buffered words still drain; m_valid drops after the last word.
- idle = (occ==0) && !inflight && fifo_empty.
- Reset mid-operation: any in-flight word and buffered words are discarded. The FIFO is reset on the same rst, so no word is lost relative to the FIFO state.

Optional Feature:
- Macro: FIFO_READER_WORD_CNT_EN.
- Defined:
  - Adds output word_cnt [15:0], which increments on every fire and wraps 0xFFFF->0x0000.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - DATA_WIDTH default.
  - occ encoding constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
  - word_cnt width constant WORD_CNT_W=16.
- One natural sub-module: stream_skid_buf, the 2-entry head/tail buffer with occ tracking. Top level keeps the read-issue and inflight logic.

Test Plan:
- Reset with FIFO holding 3 words -> m_valid=0, fifo_rd_en=0 during rst, idle=1 after reset (FIFO cleared).
- Write 0x11,0x22,0x33 into the FIFO; m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles; first m_valid 2 cycles after first fifo_rd_en; idle=1 afterwards.
- 8 words in the FIFO, m_ready=0 -> exactly 2 reads issued, occ=2, m_data holds word 0; release m_ready -> all 8 emerge in order, no gaps.
- m_ready toggling 1/0 each cycle over 16 words (0x00..0x0F) -> output sequence exactly 0x00..0x0F; no duplicates or drops; no overflow assertion.
- rst asserted while occ=2 and inflight=1 -> next cycle m_valid=0, occ=0, inflight=0; post-reset writes 0xA5 -> 0xA5 delivered.
- FIFO_READER_WORD_CNT_EN defined: 70000 fires -> word_cnt=70000 mod 65536=4464.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: widths, buffer
// occupancy encoding and the read-permission helper.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int WORD_CNT_W     = 16;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_TWO   = OCC_TWO
  } occ_e;

  // Words that will occupy the buffer after this cycle must stay below two,
  // otherwise a newly issued read would have nowhere to land.
  function automatic logic read_room(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       fire);
    logic [2:0] w_pending;
    w_pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, fire};
    return (w_pending < 3'd2);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry head/tail buffer that re-presents captured FIFO words as a
// valid/ready stream; its state is the buffer occupancy.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_fire,
  output logic [1:0]            o_occ
);

  // Handshake: a word transfers on a cycle where o_valid && i_ready; while
  // o_valid is high and i_ready low, o_data holds its value.
  occ_e                  r_state;
  occ_e                  w_next;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_fire;
  logic                  w_head_we;
  logic                  w_head_from_tail;
  logic                  w_tail_we;

  assign o_valid = (r_state != ST_EMPTY);
  assign w_fire  = o_valid && i_ready;
  assign o_fire  = w_fire;
  assign o_data  = r_head;
  assign o_occ   = r_state;

  always_comb begin
    w_next           = r_state;
    w_head_we        = 1'b0;
    w_head_from_tail = 1'b0;
    w_tail_we        = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (i_push) begin
          w_next    = ST_ONE;
          w_head_we = 1'b1;
        end
      end
      ST_ONE: begin
        case ({i_push, w_fire})
          2'b11: w_head_we = 1'b1;
          2'b10: begin
            w_tail_we = 1'b1;
            w_next    = ST_TWO;
          end
          2'b01: w_next = ST_EMPTY;
          default: w_next = ST_ONE;
        endcase
      end
      ST_TWO: begin
        // The tail always advances into the head on a pop; an arrival in the
        // same cycle refills the tail behind it.
        if (w_fire) begin
          w_head_we        = 1'b1;
          w_head_from_tail = 1'b1;
          if (i_push) w_tail_we = 1'b1;
          else        w_next    = ST_ONE;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_next;
      if (w_head_we) r_head <= w_head_from_tail ? r_tail : i_data;
      if (w_tail_we) r_tail <= i_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(r_state == ST_TWO && i_push && !w_fire));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for fifo_sync: issues reads, absorbs the one-cycle read
// latency and streams words out. Optional word counter: FIFO_READER_WORD_CNT_EN.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle,
`ifdef FIFO_READER_WORD_CNT_EN
  output logic [WORD_CNT_W-1:0] word_cnt,
`endif
  output logic [1:0]            dbg_occ,
  output logic                  dbg_inflight
);

  logic       r_inflight;
  logic       w_fire;
  logic [1:0] w_occ;

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (fifo_rd_data),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_fire  (w_fire),
    .o_occ   (w_occ)
  );

  // A pop this cycle frees a slot, so reads keep flowing at one per cycle.
  assign fifo_rd_en = !rst && !fifo_empty && read_room(w_occ, r_inflight, w_fire);

  always_ff @(posedge clk) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= fifo_rd_en;
  end

  assign idle         = (w_occ == OCC_EMPTY) && !r_inflight && fifo_empty;
  assign dbg_occ      = w_occ;
  assign dbg_inflight = r_inflight;

`ifdef FIFO_READER_WORD_CNT_EN
  logic [WORD_CNT_W-1:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (rst)         r_word_cnt <= '0;
    else if (w_fire) r_word_cnt <= r_word_cnt + 1'b1;
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule
